// File: rtl/button_conditioner.sv
// Button front-end: per channel 2-flop synchroniser, counter debouncer, registered press/release pulses.
// Define BUTTON_REPEAT_EN to add auto-repeat press pulses while a button stays held.
module button_conditioner #(
   parameter int N_BUTTONS       = 5,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 30,
   parameter int REPEAT_PERIOD   = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] btn_press,
   output logic [N_BUTTONS-1:0] btn_release,
   output logic                 any_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
      $error("button_conditioner: illegal parameter value");
   end

   logic [N_BUTTONS-1:0] sync1_q, sync2_q;
   logic [N_BUTTONS-1:0] level_q, level_d;
   logic [N_BUTTONS-1:0] press_q, press_d;
   logic [N_BUTTONS-1:0] release_q, release_d;
   logic                 any_q;
   logic [CW-1:0]        cnt_q [N_BUTTONS];
   logic [CW-1:0]        cnt_d [N_BUTTONS];

`ifdef BUTTON_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX);
   localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0]        rpt_q [N_BUTTONS];
   logic [RW-1:0]        rpt_d [N_BUTTONS];
   // 0 while waiting for the first repeat, 1 once in the periodic phase
   logic [N_BUTTONS-1:0] rpt_ph_q, rpt_ph_d;
`endif

   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
`ifdef BUTTON_REPEAT_EN
      rpt_ph_d  = '0;
`endif
      for (int i = 0; i < N_BUTTONS; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         press_d[i]   = level_d[i] & ~level_q[i];
         release_d[i] = level_q[i] & ~level_d[i];
`ifdef BUTTON_REPEAT_EN
         // Counter is zero on the press edge and on release, so it only runs during a steady hold
         rpt_d[i] = '0;
         if (level_q[i] && level_d[i]) begin
            if (rpt_q[i] == (rpt_ph_q[i] ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
               press_d[i]  = 1'b1;
               rpt_ph_d[i] = 1'b1;
            end else begin
               rpt_d[i]    = rpt_q[i] + 1'b1;
               rpt_ph_d[i] = rpt_ph_q[i];
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         any_q     <= 1'b0;
         for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_q[i] <= '0;
         end
`ifdef BUTTON_REPEAT_EN
         rpt_ph_q <= '0;
         for (int i = 0; i < N_BUTTONS; i++) begin
            rpt_q[i] <= '0;
         end
`endif
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         any_q     <= |press_d;
         for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
`ifdef BUTTON_REPEAT_EN
         rpt_ph_q <= rpt_ph_d;
         for (int i = 0; i < N_BUTTONS; i++) begin
            rpt_q[i] <= rpt_d[i];
         end
`endif
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign any_press   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized raw/reset traffic against a reference model.
module tb_button_conditioner;
   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] btn_raw;
   logic [N-1:0] btn_level, btn_press, btn_release;
   logic         any_press;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BUTTONS(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
   );

   // Reference model: level flips once the twice-delayed raw input has disagreed with it for DEB samples in a row
   logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release, nl, np, nr;
   logic         m_any;
   int           run [N];
   int           t_press [N];
   int           cyc = 0;
   int           el;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0; m_any = 1'b0;
         for (int c = 0; c < N; c++) begin
            run[c] = 0;
            t_press[c] = 0;
         end
      end else begin
         cyc++;
         nl = m_level; np = '0; nr = '0;
         for (int c = 0; c < N; c++) begin
            if (m_s2[c] != m_level[c]) begin
               run[c]++;
               if (run[c] == DEB) begin
                  nl[c] = m_s2[c];
                  run[c] = 0;
               end
            end else begin
               run[c] = 0;
            end
            if (nl[c] && !m_level[c]) begin
               np[c] = 1'b1;
               t_press[c] = cyc;
            end
            if (!nl[c] && m_level[c]) nr[c] = 1'b1;
`ifdef BUTTON_REPEAT_EN
            if (nl[c] && m_level[c]) begin
               el = cyc - t_press[c];
               if (el == RD || (el > RD && (el - RD) % RP == 0)) np[c] = 1'b1;
            end
`endif
         end
         m_s2 = m_s1; m_s1 = btn_raw;
         m_level = nl; m_press = np; m_release = nr; m_any = |np;
      end
   end

   logic [3*N:0] dut_vec, mdl_vec;
   assign dut_vec = {btn_level, btn_press, btn_release, any_press};
   assign mdl_vec = {m_level, m_press, m_release, m_any};

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; btn_raw = '0;
      tick(); tick();
      tests++;
      if (dut_vec !== '0) begin
         failed++; $display("FAIL reset_hold got=%b want=0", dut_vec);
      end
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         tests++;
         if (dut_vec !== '0) begin
            failed++; $display("FAIL reset_idle i=%0d got=%b want=0", i, dut_vec);
         end
      end
   endtask

   task automatic test_single_press();
      btn_raw = 4'b0001;
      for (int i = 1; i <= 50; i++) begin
         tick();
         tests++;
         if (dut_vec !== mdl_vec) begin
            failed++; $display("FAIL single_model i=%0d got=%b want=%b", i, dut_vec, mdl_vec);
         end
         if (i <= 12) begin
            tests++;
            if (btn_press !== ((i == 6) ? 4'b0001 : 4'b0000) || any_press !== (i == 6) ||
                btn_level !== ((i >= 6) ? 4'b0001 : 4'b0000) || btn_release !== 4'b0000) begin
               failed++;
               $display("FAIL single_edge i=%0d got lvl=%b prs=%b rel=%b any=%b want press at edge 6",
                        i, btn_level, btn_press, btn_release, any_press);
            end
         end
      end
      btn_raw = '0;
      idle(12);
   endtask

   task automatic test_bounce();
      for (int c = 0; c < 40; c++) begin
         btn_raw = (c % 4 != 3) ? 4'b0010 : 4'b0000;
         tick();
         tests++;
         if (dut_vec !== mdl_vec || btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_release[1] !== 1'b0) begin
            failed++; $display("FAIL bounce c=%0d got=%b want=%b lvl1=0", c, dut_vec, mdl_vec);
         end
      end
      btn_raw = 4'b0010;
      for (int i = 1; i <= 8; i++) begin
         tick();
         tests++;
         if (btn_press[1] !== (i == 6) || btn_level[1] !== (i >= 6) || dut_vec !== mdl_vec) begin
            failed++; $display("FAIL bounce_stable i=%0d got=%b want=%b", i, dut_vec, mdl_vec);
         end
      end
      btn_raw = '0;
      idle(12);
   endtask

   task automatic test_release();
      btn_raw = 4'b0001;
      idle(10);
      btn_raw = 4'b0000;
      for (int i = 1; i <= 10; i++) begin
         tick();
         tests++;
         if (btn_release[0] !== (i == 6) || btn_level[0] !== (i < 6) ||
             (btn_press & btn_release) !== 4'b0000 || dut_vec !== mdl_vec) begin
            failed++; $display("FAIL release i=%0d got=%b want=%b rel0 at edge 6", i, dut_vec, mdl_vec);
         end
      end
      idle(4);
   endtask

   task automatic test_simultaneous();
      int any_cnt = 0;
      btn_raw = 4'b1100;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (any_press === 1'b1) any_cnt++;
         tests++;
         if (btn_press !== ((i == 6) ? 4'b1100 : 4'b0000) || dut_vec !== mdl_vec) begin
            failed++; $display("FAIL simul i=%0d got=%b want=%b", i, dut_vec, mdl_vec);
         end
      end
      tests++;
      if (any_cnt != 1) begin
         failed++; $display("FAIL simul_any got=%0d want=1", any_cnt);
      end
      btn_raw = '0;
      idle(12);
   endtask

   task automatic test_reset_mid_hold();
      btn_raw = 4'b0001;
      idle(10);
      reset = 1'b1;
      #1;
      tests++;
      if (dut_vec !== '0) begin
         failed++; $display("FAIL rst_mid_async got=%b want=0", dut_vec);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         tests++;
         if (dut_vec !== '0) begin
            failed++; $display("FAIL rst_mid_hold i=%0d got=%b want=0", i, dut_vec);
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         tests++;
         if (btn_press[0] !== (i == 6) || btn_release !== 4'b0000 || dut_vec !== mdl_vec) begin
            failed++; $display("FAIL rst_mid_fresh i=%0d got=%b want=%b", i, dut_vec, mdl_vec);
         end
      end
      btn_raw = '0;
      idle(12);
   endtask

   task automatic test_repeat();
      int offs[$];
      int exp_offs[$];
      int p = 0;
      btn_raw = 4'b0001;
      for (int i = 1; i <= 10 && p == 0; i++) begin
         tick();
         if (btn_press[0] === 1'b1) p = i;
      end
      tests++;
      if (p != 6) begin
         failed++; $display("FAIL repeat_first got=%0d want=6", p);
      end
      offs.push_back(0);
      for (int j = 1; j <= 75; j++) begin
         tick();
         if (btn_press[0] === 1'b1) offs.push_back(j);
         tests++;
         if (dut_vec !== mdl_vec) begin
            failed++; $display("FAIL repeat_model j=%0d got=%b want=%b", j, dut_vec, mdl_vec);
         end
         if (j == 66) begin
            tests++;
            if (btn_release[0] !== 1'b1 || btn_press[0] !== 1'b0) begin
               failed++; $display("FAIL repeat_release got rel=%b prs=%b want rel=1 prs=0",
                                  btn_release[0], btn_press[0]);
            end
         end
         if (j == 60) btn_raw = '0;
      end
`ifdef BUTTON_REPEAT_EN
      exp_offs = '{0, 20, 28, 36, 44, 52, 60};
`else
      exp_offs = '{0};
`endif
      tests++;
      if (offs.size() != exp_offs.size()) begin
         failed++; $display("FAIL repeat_count got=%0d want=%0d", offs.size(), exp_offs.size());
      end else begin
         for (int k = 0; k < exp_offs.size(); k++) begin
            tests++;
            if (offs[k] != exp_offs[k]) begin
               failed++; $display("FAIL repeat_offset k=%0d got=%0d want=%0d", k, offs[k], exp_offs[k]);
            end
         end
      end
      idle(12);
   endtask

   task automatic test_random();
      int hold [N];
      int rst_left = 0;
      for (int c = 0; c < N; c++) hold[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < N; c++) begin
            if (hold[c] == 0) begin
               btn_raw[c] = ~btn_raw[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 6));
            end else begin
               hold[c]--;
            end
         end
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) reset = 1'b0;
         end else if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            rst_left = $urandom_range(1, 3);
         end
         tick();
         tests++;
         if (dut_vec !== mdl_vec || (btn_press & btn_release) !== '0) begin
            failed++; $display("FAIL random n=%0d got=%b want=%b", n, dut_vec, mdl_vec);
         end
      end
      reset = 1'b0;
      btn_raw = '0;
      idle(12);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_mid_hold();
      test_repeat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
